// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Optional alignment checking is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
package dmem_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef logic portId_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } arbState_t;

    function automatic logic [NUM_PORTS-1:0] portOneHot(input portId_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way round-robin pick; the port not granted last wins a tie.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  portId_t              lastGnt,
    output logic [NUM_PORTS-1:0] gnt
);

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = lastGnt ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported Data_Memory between core and loader.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned accesses with rsp_err_o.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] we_i,
    input  logic [AW-1:0]        addr0_i,
    input  logic [AW-1:0]        addr1_i,
    input  logic [DW-1:0]        wdata0_i,
    input  logic [DW-1:0]        wdata1_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [NUM_PORTS-1:0] rsp_valid_o,
    output logic                 rsp_err_o,
    output logic [DW-1:0]        rdata_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    output logic                 mem_write_o,
    output logic                 mem_read_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    arbState_t            stateQ, stateD;
    portId_t              lastGntQ, portQ, winId;
    logic [NUM_PORTS-1:0] pickGnt, rspValidQ;
    logic [AW-1:0]        addrQ;
    logic [DW-1:0]        wdataQ, rdataQ;
    logic                 weQ, accept, errAccess;

    dmem_rr_pick uPick (
        .req     (req_i),
        .lastGnt (lastGntQ),
        .gnt     (pickGnt)
    );

    assign winId  = pickGnt[1];
    assign accept = (stateQ == ST_IDLE) && (|req_i);
    // Gated by rst_n so no grant leaks out while reset is held.
    assign gnt_o  = (accept && rst_n) ? pickGnt : '0;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic rspErrQ;

    assign errAccess = (addrQ[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspErrQ <= 1'b0;
        end else begin
            rspErrQ <= (stateQ == ST_ACCESS) && errAccess;
        end
    end

    assign rsp_err_o = rspErrQ;
`else
    assign errAccess = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        stateD      = stateQ;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        unique case (stateQ)
            ST_IDLE: begin
                if (|req_i) stateD = ST_ACCESS;
            end
            ST_ACCESS: begin
                stateD = ST_IDLE;
                if (!errAccess) begin
                    mem_write_o = weQ;
                    mem_read_o  = ~weQ;
                end
            end
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= ST_IDLE;
            lastGntQ  <= 1'b1;
            portQ     <= 1'b0;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            rdataQ    <= '0;
            rspValidQ <= '0;
        end else begin
            stateQ    <= stateD;
            rspValidQ <= '0;
            if (accept) begin
                addrQ    <= winId ? addr1_i : addr0_i;
                wdataQ   <= winId ? wdata1_i : wdata0_i;
                weQ      <= we_i[winId];
                portQ    <= winId;
                lastGntQ <= winId;
            end
            if (stateQ == ST_ACCESS) begin
                rspValidQ <= portOneHot(portQ);
                if (!weQ && !errAccess) rdataQ <= mem_rdata_i;
            end
        end
    end

    assign mem_addr_o  = addrQ;
    assign mem_wdata_o = wdataQ;
    assign rdata_o     = rdataQ;
    assign rsp_valid_o = rspValidQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural Data_Memory model.
// Build with DMEM_ARB_ALIGN_CHECK_EN defined to exercise the misalignment path.
module tb_dmem_arbiter;

    logic        clk, rst_n;
    logic [1:0]  req_i, we_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [1:0]  gnt_o, rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_write_o, mem_read_o;

    logic [31:0] mem [0:16383];

    int nCompared   = 0;
    int nMismatched = 0;
    logic [31:0] expRdata;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_err_o   (rsp_err_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_write_o (mem_write_o),
        .mem_read_o  (mem_read_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_addr_o[15:2]];

    always @(posedge clk) begin
        if (mem_write_o) mem[mem_addr_o[15:2]] <= mem_wdata_o;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the arbiter idle; ends at the negedge carrying the response.
    task automatic doAccess(input int p, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic expStrobe, input logic expErr);
        logic [1:0] oh;
        oh = (p == 0) ? 2'b01 : 2'b10;
        req_i = oh;
        we_i[p] = w;
        if (p == 0) begin
            addr0_i = a; wdata0_i = d;
        end else begin
            addr1_i = a; wdata1_i = d;
        end
        #1;
        checkVal("gnt", 32'(gnt_o), 32'(oh));
        checkVal("idleWrite", 32'(mem_write_o), 32'd0);
        @(negedge clk);
        checkVal("gntInAccess", 32'(gnt_o), 32'd0);
        checkVal("accWrite", 32'(mem_write_o), 32'(expStrobe & w));
        checkVal("accRead", 32'(mem_read_o), 32'(expStrobe & ~w));
        if (expStrobe) checkVal("accAddr", mem_addr_o, a);
        if (expStrobe && w) checkVal("accWdata", mem_wdata_o, d);
        req_i = 2'b00;
        if (!w && expStrobe) expRdata = mem[a[15:2]];
        @(negedge clk);
        checkVal("rspValid", 32'(rsp_valid_o), 32'(oh));
        checkVal("rspErr", 32'(rsp_err_o), 32'(expErr));
        checkVal("rdata", rdata_o, expRdata);
        checkVal("writeOff", 32'(mem_write_o), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, ".gnt"}, 32'(gnt_o), 32'd0);
        checkVal({tag, ".rspValid"}, 32'(rsp_valid_o), 32'd0);
        checkVal({tag, ".rspErr"}, 32'(rsp_err_o), 32'd0);
        checkVal({tag, ".rdata"}, rdata_o, 32'd0);
        checkVal({tag, ".memAddr"}, mem_addr_o, 32'd0);
        checkVal({tag, ".memWdata"}, mem_wdata_o, 32'd0);
        checkVal({tag, ".memWrite"}, 32'(mem_write_o), 32'd0);
        checkVal({tag, ".memRead"}, 32'(mem_read_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [1:0]  expGnt [0:7];
    logic [1:0]  expRsp [0:7];
    logic [31:0] expDat [0:7];

    initial begin
        expGnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        expRsp = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        expDat = '{32'hABC, 32'hABC, 32'h1, 32'h1, 32'hABC, 32'hABC, 32'h1, 32'h1};

        rst_n = 1'b0;
        req_i = '0; we_i = '0;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
        expRdata = 32'd0;
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Store then load on port 0, back-to-back.
        doAccess(0, 1'b1, 32'h0, 32'h1, 1'b1, 1'b0);
        doAccess(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkVal("loadReturns1", rdata_o, 32'h1);

        // Fresh reset so port 0 wins the first tie.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expRdata = 32'd0;
        @(negedge clk);
        req_i = 2'b11; we_i = 2'b11;
        addr0_i = 32'h4; wdata0_i = 32'hABC;
        addr1_i = 32'hC008; wdata1_i = 32'hCBA;
        #1;
        checkVal("tieGnt0", 32'(gnt_o), 32'h1);
        @(negedge clk);
        checkVal("tieAcc0Addr", mem_addr_o, 32'h4);
        checkVal("tieAcc0Write", 32'(mem_write_o), 32'h1);
        req_i = 2'b10;
        @(negedge clk);
        checkVal("tieRsp0", 32'(rsp_valid_o), 32'h1);
        checkVal("tieGnt1", 32'(gnt_o), 32'h2);
        @(negedge clk);
        checkVal("tieAcc1Addr", mem_addr_o, 32'hC008);
        checkVal("tieAcc1Wdata", mem_wdata_o, 32'hCBA);
        req_i = 2'b00;
        @(negedge clk);
        checkVal("tieRsp1", 32'(rsp_valid_o), 32'h2);
        doAccess(0, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);
        checkVal("readback0", rdata_o, 32'hABC);
        doAccess(1, 1'b0, 32'hC008, 32'h0, 1'b1, 1'b0);
        checkVal("readback1", rdata_o, 32'hCBA);

        // Both ports hold loads; grants alternate, responses overlap new grants.
        @(negedge clk);
        req_i = 2'b11; we_i = 2'b00;
        addr0_i = 32'h0; addr1_i = 32'h4;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checkVal($sformatf("rrGnt%0d", i), 32'(gnt_o), 32'(expGnt[i]));
            checkVal($sformatf("rrRsp%0d", i), 32'(rsp_valid_o), 32'(expRsp[i]));
            if (i >= 2) checkVal($sformatf("rrData%0d", i), rdata_o, expDat[i]);
        end
        req_i = 2'b00;
        @(negedge clk);
        checkVal("rrRspLast", 32'(rsp_valid_o), 32'h2);
        checkVal("rrDataLast", rdata_o, 32'hABC);
        expRdata = 32'hABC;

        // Reset during the ACCESS cycle of a store aborts it.
        @(negedge clk);
        doAccess(0, 1'b1, 32'h8, 32'h55, 1'b1, 1'b0);
        req_i = 2'b01; we_i[0] = 1'b1; addr0_i = 32'h8; wdata0_i = 32'h112;
        #1;
        checkVal("abortGnt", 32'(gnt_o), 32'h1);
        @(negedge clk);
        req_i = 2'b00;
        checkVal("abortAccWrite", 32'(mem_write_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midAccess");
        @(negedge clk);
        checkVal("abortNoRsp", 32'(rsp_valid_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("abortNoRspAfter", 32'(rsp_valid_o), 32'd0);
        checkVal("abortMemKept", mem[2], 32'h55);
        expRdata = 32'd0;
        doAccess(0, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0);
        checkVal("abortReadback", rdata_o, 32'h55);

        // Misaligned store on port 1.
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        doAccess(1, 1'b1, 32'h6, 32'hDEAD, 1'b0, 1'b1);
        checkVal("alignRdataKept", rdata_o, 32'h55);
        checkVal("alignMemKept", mem[1], 32'hABC);
`else
        doAccess(1, 1'b1, 32'h6, 32'hDEAD, 1'b1, 1'b0);
        checkVal("unalignedPass", mem[1], 32'hDEAD);
`endif
        @(negedge clk);
        checkVal("finalIdleRsp", 32'(rsp_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
